// File: rtl/arb_pkg.sv
// Shared definitions for the memory port arbiter and its helpers.
//   arb_state_t  : arbiter FSM states (IDLE, BUSY, DONE)
//   arb_owner_t  : requester identifiers (fetch, data)
//   MEM_LAT_MIN/MAX and lat_load_val(): legal access latency range and the
//   wait-counter preload derived from it.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 15;

  // Counter preload for a given latency, clamped into the legal range so an
  // out-of-range parameter can never wrap the 4-bit counter.
  function automatic logic [3:0] lat_load_val(input int unsigned lat);
    if (lat < MEM_LAT_MIN) return 4'd0;
    if (lat > MEM_LAT_MAX) return 4'(MEM_LAT_MAX - 1);
    return 4'(lat - 1);
  endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// 4-bit loadable down-counter used to time multi-cycle memory accesses.
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset (count -> 0)
//   load     : load load_val on the next edge (has priority over counting)
//   load_val : preload value
//   zero     : high while the count is 0; the count saturates at 0
module arb_wait_cnt (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch path and
// the load/store data path. One access at a time: accept, MEM_LAT busy
// cycles driving the memory, one DONE cycle returning data and a valid pulse.
// Ports:
//   clock, reset                     : clock, async active-low reset
//   if_req/if_addr -> if_gnt/if_valid/if_rdata : fetch requester
//   d_req/d_wen/d_addr/d_wdata -> d_gnt/d_valid/d_rdata : data requester
//   mem_ren/mem_wen/mem_addr/mem_din, mem_dout : memory side
// Parameters: AW address width, DW data width, MEM_LAT access cycles (1..15).
// Build option: define ARB_FAIR_EN for round-robin arbitration; otherwise
// data always wins over fetch.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [3:0] WAIT_LOAD = lat_load_val(MEM_LAT);

  arb_state_t state, state_nxt;
  arb_owner_t owner, owner_nxt, pick;
  logic       op_wen, op_wen_nxt;
  logic       accept, wait_zero;

  logic          if_gnt_nxt, if_valid_nxt, d_gnt_nxt, d_valid_nxt;
  logic          mem_ren_nxt, mem_wen_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_din_nxt, if_rdata_nxt, d_rdata_nxt;

  arb_wait_cnt u_wait_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .load_val (WAIT_LOAD),
    .zero     (wait_zero)
  );

  // Requests are sampled in IDLE and also on the edge leaving DONE, which
  // gives back-to-back service without an extra idle cycle.
  assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && (if_req || d_req);

`ifdef ARB_FAIR_EN
  arb_owner_t last_own;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_own <= OWN_IF;
    end else if (accept) begin
      last_own <= pick;
    end
  end

  always_comb begin
    if (if_req && d_req) begin
      pick = (last_own == OWN_D) ? OWN_IF : OWN_D;
    end else begin
      pick = d_req ? OWN_D : OWN_IF;
    end
  end
`else
  always_comb begin
    pick = d_req ? OWN_D : OWN_IF;
  end
`endif

  // State register (plus the captured owner and access type).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      owner  <= OWN_IF;
      op_wen <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      op_wen <= op_wen_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    op_wen_nxt = op_wen;
    if (accept) begin
      state_nxt  = ST_BUSY;
      owner_nxt  = pick;
      op_wen_nxt = (pick == OWN_D) && d_wen;
    end else begin
      unique case (state)
        ST_BUSY: if (wait_zero) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    if_gnt_nxt   = 1'b0;
    if_valid_nxt = 1'b0;
    d_gnt_nxt    = 1'b0;
    d_valid_nxt  = 1'b0;
    mem_ren_nxt  = 1'b0;
    mem_wen_nxt  = 1'b0;
    mem_addr_nxt = mem_addr;
    mem_din_nxt  = mem_din;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    if (accept) begin
      if (pick == OWN_D) begin
        d_gnt_nxt    = 1'b1;
        mem_addr_nxt = d_addr;
        mem_din_nxt  = d_wdata;
        mem_ren_nxt  = !d_wen;
        mem_wen_nxt  = d_wen;   // single write: only the first BUSY cycle
      end else begin
        if_gnt_nxt   = 1'b1;
        mem_addr_nxt = if_addr;
        mem_ren_nxt  = 1'b1;
      end
    end else if (state == ST_BUSY) begin
      if (wait_zero) begin
        if (owner == OWN_D) begin
          d_valid_nxt = 1'b1;
          if (!op_wen) d_rdata_nxt = mem_dout;
        end else begin
          if_valid_nxt = 1'b1;
          if_rdata_nxt = mem_dout;
        end
      end else begin
        mem_ren_nxt = !op_wen;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_gnt   <= 1'b0;
      if_valid <= 1'b0;
      d_gnt    <= 1'b0;
      d_valid  <= 1'b0;
      mem_ren  <= 1'b0;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_gnt   <= if_gnt_nxt;
      if_valid <= if_valid_nxt;
      d_gnt    <= d_gnt_nxt;
      d_valid  <= d_valid_nxt;
      mem_ren  <= mem_ren_nxt;
      mem_wen  <= mem_wen_nxt;
      mem_addr <= mem_addr_nxt;
      mem_din  <= mem_din_nxt;
      if_rdata <= if_rdata_nxt;
      d_rdata  <= d_rdata_nxt;
    end
  end

endmodule
